xbar_flow_eval: RTL and testbench

Sequential, parametrised flow-based crossbar evaluator. Each crossbar cell holds a programmable literal: off, on, input variable, or negated input variable. On start, the block injects flow on a source wordline and propagates it iteratively through bitlines and wordlines until the reachable set stops changing. It then reports whether the output wordline is reached. It replaces fixed, hard-wired crossbar netlists with a run-time programmable instance that sits between the synthesis flow's configuration loader and the result checker.

---
 rtl/xbar_flow_eval.sv | 161 ++++++++++++++++
 tb/tb_xbar_flow_eval.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_flow_eval.sv
// Run-time programmable crossbar evaluator: flow is injected on SRC_ROW and propagated
// through conducting cells until the reachable wordline/bitline sets stop growing.
module xbar_flow_eval #(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 4,
    parameter int unsigned NVARS    = 4,
    parameter int unsigned SRC_ROW  = 0,
    parameter int unsigned OUT_ROW  = 1,
    parameter int unsigned MAX_ITER = ROWS + COLS,
    parameter int unsigned RW       = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int unsigned CW       = (COLS > 1) ? $clog2(COLS) : 1,
    parameter int unsigned VW       = (NVARS > 1) ? $clog2(NVARS) : 1,
    parameter int unsigned IW       = $clog2(MAX_ITER + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_we,
    input  logic [RW-1:0]   cfg_row,
    input  logic [CW-1:0]   cfg_col,
    input  logic [1:0]      cfg_mode,
    input  logic [VW-1:0]   cfg_var,
    output logic            cfg_err,
    input  logic            start,
    input  logic [NVARS-1:0] vars,
    output logic            busy,
    output logic            done,
    output logic            result,
    output logic            converged,
    output logic [IW-1:0]   iter_count,
    output logic [ROWS-1:0] row_flow
);

    typedef enum logic [1:0] {StIdle, StLoad, StProp, StDone} state_e;

    state_e                      state_q;
    logic [1:0]                  mode_q [ROWS][COLS];
    logic [VW-1:0]               sel_q  [ROWS][COLS];
    logic [NVARS-1:0]            vars_q;
    logic [ROWS-1:0][COLS-1:0]   g_q, g_d;
    logic [ROWS-1:0]             row_q, row_n;
    logic [COLS-1:0]             col_q, col_n;
    logic                        cfg_ok;
    logic                        fixpoint;
    logic                        at_limit;

    // Variable index only matters for the var / negated-var modes.
    assign cfg_ok = (32'(cfg_row) < ROWS) && (32'(cfg_col) < COLS) &&
                    (!cfg_mode[1] || (32'(cfg_var) < NVARS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < int'(ROWS); r++) begin
                for (int c = 0; c < int'(COLS); c++) begin
                    mode_q[r][c] <= 2'b00;
                    sel_q[r][c]  <= '0;
                end
            end
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (cfg_we) begin
                if (state_q == StIdle && cfg_ok) begin
                    mode_q[cfg_row][cfg_col] <= cfg_mode;
                    sel_q[cfg_row][cfg_col]  <= cfg_var;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        g_d = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                case (mode_q[r][c])
                    2'b00:   g_d[r][c] = 1'b0;
                    2'b01:   g_d[r][c] = 1'b1;
                    2'b10:   g_d[r][c] = vars_q[sel_q[r][c]];
                    default: g_d[r][c] = ~vars_q[sel_q[r][c]];
                endcase
            end
        end
    end

    // One propagation step: bitlines from current wordlines, then wordlines from new bitlines.
    always_comb begin
        col_n = '0;
        for (int c = 0; c < int'(COLS); c++) begin
            for (int r = 0; r < int'(ROWS); r++) begin
                col_n[c] = col_n[c] | (row_q[r] & g_q[r][c]);
            end
        end
        row_n = '0;
        row_n[SRC_ROW] = 1'b1;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                row_n[r] = row_n[r] | (col_n[c] & g_q[r][c]);
            end
        end
    end

    assign fixpoint = (row_n == row_q) && (col_n == col_q);
    assign at_limit = (32'(iter_count) + 32'd1) >= MAX_ITER;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            vars_q     <= '0;
            g_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            iter_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= 1'b0;
            converged  <= 1'b0;
            row_flow   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        vars_q    <= vars;
                        busy      <= 1'b1;
                        result    <= 1'b0;
                        converged <= 1'b0;
                        row_flow  <= '0;
                        state_q   <= StLoad;
                    end
                end
                StLoad: begin
                    g_q            <= g_d;
                    row_q          <= '0;
                    row_q[SRC_ROW] <= 1'b1;
                    col_q          <= '0;
                    iter_count     <= '0;
                    state_q        <= StProp;
                end
                StProp: begin
                    row_q      <= row_n;
                    col_q      <= col_n;
                    iter_count <= iter_count + 1'b1;
                    if (fixpoint || at_limit) begin
                        converged <= fixpoint;
                        done      <= 1'b1;
                        result    <= row_n[OUT_ROW];
                        row_flow  <= row_n;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_xbar_flow_eval.sv
// Directed and randomized checks of xbar_flow_eval against a set-reachability model; a second
// instance with MAX_ITER=1 exercises forced termination on the same stimulus.
module tb_xbar_flow_eval;

    localparam int R  = 3;
    localparam int C  = 3;
    localparam int MI = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_row = '0, cfg_col = '0, cfg_mode = '0, cfg_var = '0;
    logic       start = 1'b0;
    logic [2:0] vars = '0;

    logic       a_err, a_busy, a_done, a_res, a_conv;
    logic [2:0] a_iter, a_flow;
    logic       b_err, b_busy, b_done, b_res, b_conv;
    logic [0:0] b_iter;
    logic [2:0] b_flow;

    int checks = 0;
    int errors = 0;
    int md[R][C];
    int mv[R][C];

    always #5 clk = ~clk;

    xbar_flow_eval #(.ROWS(3), .COLS(3), .NVARS(3), .SRC_ROW(0), .OUT_ROW(1), .MAX_ITER(MI)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_col(cfg_col),
        .cfg_mode(cfg_mode), .cfg_var(cfg_var), .cfg_err(a_err), .start(start), .vars(vars),
        .busy(a_busy), .done(a_done), .result(a_res), .converged(a_conv),
        .iter_count(a_iter), .row_flow(a_flow)
    );

    xbar_flow_eval #(.ROWS(3), .COLS(3), .NVARS(3), .SRC_ROW(0), .OUT_ROW(1), .MAX_ITER(1)) dut_lim (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_col(cfg_col),
        .cfg_mode(cfg_mode), .cfg_var(cfg_var), .cfg_err(b_err), .start(start), .vars(vars),
        .busy(b_busy), .done(b_done), .result(b_res), .converged(b_conv),
        .iter_count(b_iter), .row_flow(b_flow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reachability rounds over sets of wordlines/bitlines until nothing new is reached.
    task automatic model(input logic [2:0] v, input int maxit, output bit res, output bit conv,
                         output int it, output logic [2:0] flow);
        bit g[R][C];
        bit rr[R], cr[C], nr[R], nc[C];
        bit same;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                case (md[r][c])
                    0:       g[r][c] = 1'b0;
                    1:       g[r][c] = 1'b1;
                    2:       g[r][c] = v[mv[r][c]];
                    default: g[r][c] = !v[mv[r][c]];
                endcase
        for (int r = 0; r < R; r++) rr[r] = (r == 0);
        for (int c = 0; c < C; c++) cr[c] = 1'b0;
        it = 0;
        conv = 1'b0;
        while (1) begin
            for (int c = 0; c < C; c++) begin
                nc[c] = 1'b0;
                for (int r = 0; r < R; r++) if (rr[r] && g[r][c]) nc[c] = 1'b1;
            end
            for (int r = 0; r < R; r++) begin
                nr[r] = (r == 0);
                for (int c = 0; c < C; c++) if (nc[c] && g[r][c]) nr[r] = 1'b1;
            end
            it++;
            same = 1'b1;
            for (int r = 0; r < R; r++) if (nr[r] != rr[r]) same = 1'b0;
            for (int c = 0; c < C; c++) if (nc[c] != cr[c]) same = 1'b0;
            rr = nr;
            cr = nc;
            if (same) begin
                conv = 1'b1;
                break;
            end
            if (it >= maxit) break;
        end
        res = rr[1];
        for (int r = 0; r < R; r++) flow[r] = rr[r];
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic write_cell(input int r, input int c, input int m, input int v, input bit exp_err);
        cfg_we   = 1'b1;
        cfg_row  = 2'(r);
        cfg_col  = 2'(c);
        cfg_mode = 2'(m);
        cfg_var  = 2'(v);
        @(negedge clk);
        cfg_we = 1'b0;
        check("cfg_err_a", 32'(a_err), 32'(exp_err));
        check("cfg_err_b", 32'(b_err), 32'(exp_err));
        if (!exp_err) begin
            md[r][c] = m;
            mv[r][c] = v;
        end
    endtask

    task automatic run_eval(input logic [2:0] v, input bit disturb, input bit wr, input string tag);
        bit ea_res, ea_conv, eb_res, eb_conv;
        int ea_it, eb_it;
        logic [2:0] ea_flow, eb_flow;
        int na, nb, pa, pb;
        logic ra, ca, rb, cb;
        logic [2:0] ia, fa, fb;
        logic [0:0] ib;
        if (wr) begin
            cfg_we = 1'b1; cfg_row = 2'd0; cfg_col = 2'd1; cfg_mode = 2'd1; cfg_var = 2'd0;
            md[0][1] = 1; mv[0][1] = 0;
        end
        model(v, MI, ea_res, ea_conv, ea_it, ea_flow);
        model(v, 1, eb_res, eb_conv, eb_it, eb_flow);
        start = 1'b1;
        vars  = v;
        @(negedge clk);
        start  = 1'b0;
        cfg_we = 1'b0;
        vars   = 3'($urandom);
        if (wr) check({tag, "_wr_err"}, 32'(a_err), 32'd0);
        check({tag, "_busy_a"}, 32'(a_busy), 32'd1);
        check({tag, "_busy_b"}, 32'(b_busy), 32'd1);
        na = 0; nb = 0; pa = 0; pb = 0;
        ra = 0; ca = 0; ia = 0; fa = 0; rb = 0; cb = 0; ib = 0; fb = 0;
        for (int n = 1; n <= 40; n++) begin
            if (disturb && n == 1) begin
                start = 1'b1; vars = ~v;
                cfg_we = 1'b1; cfg_row = 2'd0; cfg_col = 2'd1; cfg_mode = 2'd1; cfg_var = 2'd0;
            end
            @(negedge clk);
            if (disturb && n == 1) begin
                start = 1'b0; cfg_we = 1'b0;
                check({tag, "_busy_err_a"}, 32'(a_err), 32'd1);
                check({tag, "_busy_err_b"}, 32'(b_err), 32'd1);
            end
            if (a_done) begin
                pa++;
                if (na == 0) begin
                    na = n; ra = a_res; ca = a_conv; ia = a_iter; fa = a_flow;
                    check({tag, "_busy_at_done_a"}, 32'(a_busy), 32'd1);
                end
            end
            if (b_done) begin
                pb++;
                if (nb == 0) begin
                    nb = n; rb = b_res; cb = b_conv; ib = b_iter; fb = b_flow;
                end
            end
            if (na != 0 && nb != 0 && n > ((na > nb) ? na : nb) + 2) break;
        end
        check({tag, "_got_done_a"}, 32'(na != 0), 32'd1);
        check({tag, "_latency_a"}, 32'(na), 32'(ea_it + 1));
        check({tag, "_result_a"}, 32'(ra), 32'(ea_res));
        check({tag, "_conv_a"}, 32'(ca), 32'(ea_conv));
        check({tag, "_iter_a"}, 32'(ia), 32'(ea_it));
        check({tag, "_flow_a"}, 32'(fa), 32'(ea_flow));
        check({tag, "_pulses_a"}, 32'(pa), 32'd1);
        check({tag, "_idle_a"}, 32'(a_busy), 32'd0);
        check({tag, "_held_a"}, 32'(a_res), 32'(ea_res));
        check({tag, "_latency_b"}, 32'(nb), 32'(eb_it + 1));
        check({tag, "_result_b"}, 32'(rb), 32'(eb_res));
        check({tag, "_conv_b"}, 32'(cb), 32'(eb_conv));
        check({tag, "_iter_b"}, 32'(ib), 32'(eb_it));
        check({tag, "_flow_b"}, 32'(fb), 32'(eb_flow));
        check({tag, "_pulses_b"}, 32'(pb), 32'd1);
    endtask

    initial begin
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                md[r][c] = 0;
                mv[r][c] = 0;
            end
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_result", 32'(a_res), 32'd0);
        check("rst_conv", 32'(a_conv), 32'd0);
        check("rst_iter", 32'(a_iter), 32'd0);
        check("rst_flow", 32'(a_flow), 32'd0);
        check("rst_cfg_err", 32'(a_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_eval(3'b000, 1'b0, 1'b0, "all_off");

        write_cell(0, 0, 2, 0, 1'b0);
        write_cell(1, 0, 2, 1, 1'b0);
        run_eval(3'b011, 1'b0, 1'b0, "two_var_hit");
        run_eval(3'b001, 1'b0, 1'b0, "two_var_miss");

        write_cell(0, 0, 1, 0, 1'b0);
        write_cell(1, 0, 0, 0, 1'b0);
        write_cell(2, 0, 1, 0, 1'b0);
        write_cell(2, 1, 3, 0, 1'b0);
        write_cell(1, 1, 1, 0, 1'b0);
        run_eval(3'b000, 1'b0, 1'b0, "sneak_hit");
        run_eval(3'b001, 1'b0, 1'b0, "sneak_miss");

        run_eval(3'b001, 1'b1, 1'b0, "disturb");
        run_eval(3'b001, 1'b0, 1'b0, "after_disturb");

        write_cell(3, 0, 1, 0, 1'b1);
        write_cell(0, 3, 1, 0, 1'b1);
        write_cell(0, 1, 2, 3, 1'b1);
        run_eval(3'b001, 1'b0, 1'b0, "after_range");

        run_eval(3'b001, 1'b0, 1'b1, "write_with_start");

        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < 3; k++)
                write_cell(int'($urandom_range(0, R - 1)), int'($urandom_range(0, C - 1)),
                           int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0);
            run_eval(3'($urandom), 1'b0, 1'b0, "random");
        end

        // Abort in the middle of propagation with a chain that needs several iterations.
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) write_cell(r, c, 0, 0, 1'b0);
        write_cell(0, 0, 1, 0, 1'b0);
        write_cell(2, 0, 1, 0, 1'b0);
        write_cell(2, 1, 1, 0, 1'b0);
        write_cell(1, 1, 1, 0, 1'b0);
        start = 1'b1;
        vars  = 3'b000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(a_busy), 32'd0);
        check("abort_result", 32'(a_res), 32'd0);
        check("abort_done", 32'(a_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check("abort_no_done", 32'(a_done), 32'd0);
        end
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) md[r][c] = 0;
        run_eval(3'b111, 1'b0, 1'b0, "after_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
